// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS data-memory responder: FSM states, bus widths, helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a. The optional DMEM_ALIGN_CHECK_EN build uses misaligned().
package mips_mem_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Number of word-index bits needed to address a DEPTH_WORDS-deep array.
    function automatic int idx_w(input int depth_words);
        return $clog2(depth_words);
    endfunction

    // Contiguous halfwords must be halfword aligned; full words must be word aligned.
    function automatic logic misaligned(input logic [BE_W-1:0] be, input logic [1:0] addr_lo);
        logic halfword;
        logic fullword;
        halfword = (be == 4'b0011) || (be == 4'b1100);
        fullword = (be == 4'b1111);
        return (halfword && addr_lo[0]) || (fullword && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mips_dmem_responder_if.sv
// Load/store bus between the MIPS core (master) and the data-memory responder (slave).
// Latency: n/a (wires only).
// Backpressure: valid/ready request, one-cycle resp_valid strobe; resp_err only with DMEM_ALIGN_CHECK_EN.
interface mips_dmem_responder_if;
    import mips_mem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
    logic              resp_err;
`endif

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, resp_valid, resp_rdata
`ifdef DMEM_ALIGN_CHECK_EN
        , input resp_err
`endif
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, resp_valid, resp_rdata
`ifdef DMEM_ALIGN_CHECK_EN
        , output resp_err
`endif
    );

endinterface

// File: rtl/mips_dmem_array.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Latency: write and read both take effect at the enabled edge; rdata holds until the next enabled read.
// Backpressure: none; every enabled cycle is serviced.
module mips_dmem_array
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    localparam int IDX_W = idx_w(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Byte-lane writes; storage is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register: loads the whole word, ignoring be, and holds it otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MIPS load/store port; optional alignment check under DMEM_ALIGN_CHECK_EN.
// Latency: resp_valid is high LATENCY cycles after the accept edge; one transaction every LATENCY+1 cycles.
// Backpressure: req_ready is low from the accept edge until the RESP cycle has ended.
module mips_dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_dmem_responder_if.slave  bus,
    output logic                  busy
);

    localparam int IDX_W = idx_w(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY + 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               ready_q;
    logic               resp_valid_q;
    logic               busy_q;
    logic               l_we;
    logic [IDX_W-1:0]   l_idx;
    logic [DATA_W-1:0]  l_wdata;
    logic [BE_W-1:0]    l_be;
    logic               l_mis;
    logic               mis_now;
    logic               into_resp;
    logic               mem_en;
    logic               a_we;
    logic [IDX_W-1:0]   a_idx;
    logic [DATA_W-1:0]  a_wdata;
    logic [BE_W-1:0]    a_be;
    logic               a_mis;
    logic [DATA_W-1:0]  a_rdata;
    logic               unused_addr_bits;

`ifdef DMEM_ALIGN_CHECK_EN
    logic               err_q;
    assign mis_now      = misaligned(bus.req_be, bus.req_addr[1:0]);
    assign bus.resp_err = err_q;
`else
    assign mis_now      = 1'b0;
`endif

    // Only the word-index bits select storage; the rest wrap away.
    assign unused_addr_bits = ^{bus.req_addr[DATA_W-1:IDX_W+2], bus.req_addr[1:0]};

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = a_rdata;
    assign busy           = busy_q;

    // The array is touched on the edge that enters RESP, so load data is visible during RESP.
    // With LATENCY==1 that edge is the accept edge, so the live request fields feed the array.
    always_comb begin
        a_we      = l_we;
        a_idx     = l_idx;
        a_wdata   = l_wdata;
        a_be      = l_be;
        a_mis     = l_mis;
        into_resp = (state == WAIT) && (cnt == CNT_W'(1));
        if (state == IDLE) begin
            a_we      = bus.req_we;
            a_idx     = bus.req_addr[IDX_W+1:2];
            a_wdata   = bus.req_wdata;
            a_be      = bus.req_be;
            a_mis     = mis_now;
            into_resp = bus.req_valid && (LATENCY == 1);
        end
        mem_en = into_resp && !a_mis && !reset;
    end

    mips_dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (mem_en),
        .we    (a_we),
        .be    (a_be),
        .idx   (a_idx),
        .wdata (a_wdata),
        .rdata (a_rdata)
    );

    // Request FSM: accept in IDLE, count down wait states, strobe the response for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            l_we         <= 1'b0;
            l_idx        <= '0;
            l_wdata      <= '0;
            l_be         <= '0;
            l_mis        <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        l_we    <= bus.req_we;
                        l_idx   <= bus.req_addr[IDX_W+1:2];
                        l_wdata <= bus.req_wdata;
                        l_be    <= bus.req_be;
                        l_mis   <= mis_now;
                        cnt     <= CNT_W'(LATENCY - 1);
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (LATENCY == 1) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
                            err_q        <= mis_now;
`endif
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
`ifdef DMEM_ALIGN_CHECK_EN
                        err_q        <= l_mis;
`endif
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    resp_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                    busy_q       <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
                    err_q        <= 1'b0;
`endif
                end
                default: begin
                    state        <= IDLE;
                    resp_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: one instance at LATENCY=2, one at LATENCY=1, shared clock and reset.
// Latency: checks the accept-to-response gap and accept spacing under held req_valid.
// Backpressure: drives req_valid as a master; alignment checks run when DMEM_ALIGN_CHECK_EN is defined.
module tb_mips_dmem_responder;
    import mips_mem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic busy_a;
    logic busy_b;

    always #5 clk = ~clk;

    mips_dmem_responder_if ifa();
    mips_dmem_responder_if ifb();

    mips_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa),
        .busy  (busy_a)
    );

    mips_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb),
        .busy  (busy_b)
    );

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One complete transaction on the LATENCY=2 instance; lat counts edges from accept to resp_valid.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rd, output int lat,
                       output logic err, output logic busy_ok, output logic one_shot);
        int n;
        @(negedge clk);
        ifa.req_valid = 1'b1;
        ifa.req_we    = we;
        ifa.req_addr  = addr;
        ifa.req_wdata = wdata;
        ifa.req_be    = be;
        n = 0;
        while (ifa.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        // Scramble the request after acceptance; it must have been latched already.
        ifa.req_valid = 1'b0;
        ifa.req_we    = ~we;
        ifa.req_addr  = 32'hFFFF_FFFC;
        ifa.req_wdata = 32'h0BAD_0BAD;
        ifa.req_be    = 4'hF;
        lat     = 1;
        busy_ok = busy_a;
        while (ifa.resp_valid !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
            busy_ok = busy_ok & busy_a;
        end
        rd = ifa.resp_rdata;
`ifdef DMEM_ALIGN_CHECK_EN
        err = ifa.resp_err;
`else
        err = 1'b0;
`endif
        @(posedge clk);
        #1;
        one_shot = !ifa.resp_valid;
`ifdef DMEM_ALIGN_CHECK_EN
        one_shot = one_shot & !ifa.resp_err;
`endif
    endtask

    logic [31:0] rd;
    int          lat;
    logic        err;
    logic        busy_ok;
    logic        one_shot;
    int          acc_a[4];
    int          acc_b[4];
    int          na;
    int          nb;
    int          bad_rdy;
    int          resp_cnt;

    initial begin
        vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000};
        vt[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 32'hDEAD_BEEF};
        vt[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'b1111, 32'hDEAD_BEEF};
        vt[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 32'hDEAD_BEEF};
        vt[4]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'b0000, 32'h11BB_33DD};
        vt[5]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 4'b1111, 32'h11BB_33DD};
        vt[6]  = '{1'b1, 32'h0000_0400, 32'h0000_0055, 4'b1111, 32'h11BB_33DD};
        vt[7]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'b1111, 32'h0000_0055};
        vt[8]  = '{1'b1, 32'h0000_0030, 32'h0000_0000, 4'b1111, 32'h0000_0055};
        vt[9]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0000_0055};
        vt[10] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 32'hDEAD_BEEF};

        reset         = 1'b1;
        ifa.req_valid = 1'b0;
        ifa.req_we    = 1'b0;
        ifa.req_addr  = '0;
        ifa.req_wdata = '0;
        ifa.req_be    = '0;
        ifb.req_valid = 1'b0;
        ifb.req_we    = 1'b0;
        ifb.req_addr  = '0;
        ifb.req_wdata = '0;
        ifb.req_be    = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", 32'(ifa.req_ready), 32'd1);
        check("reset_resp_valid", 32'(ifa.resp_valid), 32'd0);
        check("reset_resp_rdata", ifa.resp_rdata, 32'd0);
        check("reset_busy", 32'(busy_a), 32'd0);
        check("reset_req_ready_l1", 32'(ifb.req_ready), 32'd1);
`ifdef DMEM_ALIGN_CHECK_EN
        check("reset_resp_err", 32'(ifa.resp_err), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Directed store/load table on the LATENCY=2 instance.
        for (int i = 0; i < 11; i++) begin
            txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, rd, lat, err, busy_ok, one_shot);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
            check($sformatf("vec%0d_busy", i), 32'(busy_ok), 32'd1);
            check($sformatf("vec%0d_one_cycle", i), 32'(one_shot), 32'd1);
`ifdef DMEM_ALIGN_CHECK_EN
            check($sformatf("vec%0d_err", i), 32'(err), 32'd0);
`endif
        end

        // Back-to-back loads with req_valid held high on both instances.
        na      = 0;
        nb      = 0;
        bad_rdy = 0;
        @(negedge clk);
        ifa.req_valid = 1'b1;
        ifa.req_we    = 1'b0;
        ifa.req_addr  = 32'h10;
        ifa.req_be    = 4'hF;
        ifb.req_valid = 1'b1;
        ifb.req_we    = 1'b0;
        ifb.req_addr  = 32'h10;
        ifb.req_be    = 4'hF;
        for (int cyc = 0; cyc < 60 && (na < 4 || nb < 4); cyc++) begin
            if (ifa.req_ready && na < 4) begin
                acc_a[na] = cyc;
                na++;
            end
            if (ifb.req_ready && nb < 4) begin
                acc_b[nb] = cyc;
                nb++;
            end
            if (ifa.resp_valid && ifa.req_ready) bad_rdy++;
            if (ifb.resp_valid && ifb.req_ready) bad_rdy++;
            if (busy_a == ifa.req_ready) bad_rdy++;
            if (busy_b == ifb.req_ready) bad_rdy++;
            @(posedge clk);
            @(negedge clk);
            if (na == 4) ifa.req_valid = 1'b0;
            if (nb == 4) ifb.req_valid = 1'b0;
        end
        ifa.req_valid = 1'b0;
        ifb.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("b2b_accepts_l2", 32'(na), 32'd4);
        check("b2b_accepts_l1", 32'(nb), 32'd4);
        check("b2b_ready_low_when_busy", 32'(bad_rdy), 32'd0);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("b2b_gap_l2_%0d", i), 32'(acc_a[i] - acc_a[i-1]), 32'd3);
            check($sformatf("b2b_gap_l1_%0d", i), 32'(acc_b[i] - acc_b[i-1]), 32'd2);
        end
        check("b2b_rdata_l2", ifa.resp_rdata, 32'hDEAD_BEEF);

        // Reset while a store is waiting: no response and no commit.
        @(negedge clk);
        ifa.req_valid = 1'b1;
        ifa.req_we    = 1'b1;
        ifa.req_addr  = 32'h30;
        ifa.req_wdata = 32'h1234_5678;
        ifa.req_be    = 4'hF;
        @(posedge clk);
        #1;
        ifa.req_valid = 1'b0;
        check("midrst_accepted", 32'(busy_a), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        resp_cnt = 0;
        @(posedge clk);
        #1;
        if (ifa.resp_valid) resp_cnt++;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ifa.resp_valid) resp_cnt++;
        end
        check("midrst_no_resp", 32'(resp_cnt), 32'd0);
        check("midrst_idle", 32'(busy_a), 32'd0);
        txn(1'b0, 32'h30, 32'h0, 4'hF, rd, lat, err, busy_ok, one_shot);
        check("midrst_no_commit", rd, 32'h0);
        check("midrst_latency", 32'(lat), 32'd2);

        // A request presented together with reset is dropped.
        @(negedge clk);
        reset         = 1'b1;
        ifa.req_valid = 1'b1;
        ifa.req_we    = 1'b0;
        ifa.req_addr  = 32'h10;
        @(posedge clk);
        #1;
        check("rst_req_not_accepted", 32'(busy_a), 32'd0);
        check("rst_req_ready", 32'(ifa.req_ready), 32'd1);
        @(negedge clk);
        ifa.req_valid = 1'b0;
        reset         = 1'b0;
        @(posedge clk);
        #1;
        check("rst_req_still_idle", 32'(busy_a), 32'd0);

`ifdef DMEM_ALIGN_CHECK_EN
        txn(1'b0, 32'h10, 32'h0, 4'hF, rd, lat, err, busy_ok, one_shot);
        check("align_pre_load", rd, 32'hDEAD_BEEF);
        txn(1'b0, 32'h32, 32'h0, 4'hF, rd, lat, err, busy_ok, one_shot);
        check("align_word_err", 32'(err), 32'd1);
        check("align_word_rdata_held", rd, 32'hDEAD_BEEF);
        check("align_word_one_cycle", 32'(one_shot), 32'd1);
        check("align_word_latency", 32'(lat), 32'd2);
        txn(1'b0, 32'h11, 32'h0, 4'b0011, rd, lat, err, busy_ok, one_shot);
        check("align_half_err", 32'(err), 32'd1);
        txn(1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, rd, lat, err, busy_ok, one_shot);
        check("align_store_err", 32'(err), 32'd1);
        txn(1'b0, 32'h10, 32'h0, 4'hF, rd, lat, err, busy_ok, one_shot);
        check("align_store_no_write", rd, 32'hDEAD_BEEF);
        check("align_ok_err_low", 32'(err), 32'd0);
        txn(1'b0, 32'h30, 32'h0, 4'hF, rd, lat, err, busy_ok, one_shot);
        check("align_aligned_err", 32'(err), 32'd0);
        check("align_aligned_rdata", rd, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mips_dmem_responder.md
Name: mips_dmem_responder

Overview:
- Data-memory responder (slave) for the MIPS core's load/store port: the memory end of the core's data bus.
- Accepts one request at a time through a valid/ready handshake and holds it for a programmable number of wait states.
- Returns read data, or commits write data, with a one-cycle response strobe.
- Replaces the zero-latency combinational data memory, so multi-cycle memory timing can be exercised from the processor testbench.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; must be a power of two, at least 4.
- LATENCY, 2, cycles from the accept edge to the cycle in which resp_valid is high; must be at least 1.

Ports:
- clk  in  1  rising-edge clock, the core clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables; bit i controls byte lane [8i+7:8i].
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  load data; meaningful when resp_valid is high on a load.
- resp_err  out  1  misalignment error, present only when the optional feature is compiled in.
- busy  out  1  a transaction is in flight (state is not IDLE).

Behaviour:
- The clock port is clk and the reset port is reset. There is one clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, wait counter=0. Memory contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. When req_valid=1, the request is accepted. On acceptance, latch we, addr, wdata, be and load the counter with LATENCY-1. Go to RESP if LATENCY==1, otherwise go to WAIT.
  - WAIT: req_ready=0. The counter decrements each cycle. When the counter reaches 1, go to RESP on the next edge. The total gap is exactly LATENCY cycles.
  - RESP: resp_valid=1 for exactly one cycle, then return to IDLE. req_ready=0 during this cycle.
- Timing: a request accepted at edge N produces resp_valid in cycle N+LATENCY. The next request can be accepted at edge N+LATENCY+1, so the maximum throughput is one transaction every LATENCY+1 cycles.
- Word index = latched addr[log2(DEPTH_WORDS)+1 : 2]. Higher address bits are ignored, so accesses wrap modulo DEPTH_WORDS words. addr[1:0] is ignored unless the optional feature is compiled in.
- Stores: bytes with be set are written at the RESP edge; other bytes are unchanged. be=0 performs no write but still responds. resp_rdata is not updated on a store.
- Loads: resp_rdata is loaded with the full stored word (all four lanes, regardless of be) and is valid in the RESP cycle. It then holds its value until the next load response or reset.
- The responder never has more than one transaction outstanding. req_* inputs are sampled only at the accept edge; changes to them while busy have no effect.
- Reset asserted during WAIT or RESP:
  - The transaction is abandoned; there is no response.
  - A pending store is not committed if reset is high at the would-be RESP edge.
  - The FSM is in IDLE on the cycle after reset.
- A request presented in the same cycle as reset is not accepted.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - At accept, the access is misaligned if it is a contiguous halfword with be=0011 or be=1100 and addr[0]=1, or a full word with be=1111 and addr[1:0]!=0.
  - A misaligned access responds at the normal time with resp_err=1 for the RESP cycle only.
  - A misaligned store writes nothing. A misaligned load leaves resp_rdata unchanged.
  - resp_err is 0 at all other times.
- Undefined: the resp_err port is absent and every access is treated as aligned.

Decomposition:
- Shared package mips_mem_pkg:
  - state encoding enum (IDLE/WAIT/RESP);
  - DATA_W=32 and BE_W=4;
  - function for the word-index width, clog2(DEPTH_WORDS).
- One natural sub-module, mips_dmem_array: synchronous single-port RAM with byte-enable write and registered read. The responder FSM instantiates it and pulses its enable in RESP.

Test Plan:
- Basic store/load: store 0xDEADBEEF to 0x10 with be=1111, then load 0x10 with LATENCY=2 -> resp_valid exactly 2 cycles after each accept; rdata=0xDEADBEEF; busy high throughout.
- Byte enables: word 0x20 holds 0x11223344; store 0xAABBCCDD with be=0101 -> load returns 0x11BB33DD.
- Wrap-around with DEPTH_WORDS=256: store 0x55 to 0x400 -> load of 0x000 returns 0x00000055.
- Back-to-back: req_valid held high with four loads -> accepts spaced LATENCY+1 cycles apart; req_ready low during WAIT and RESP. Repeat with LATENCY=1 -> accepts 2 cycles apart.
- Reset mid-operation: store 0x12345678 to 0x30 (previously 0) with reset pulsed during WAIT -> no resp_valid; a subsequent load of 0x30 returns 0.
- With DMEM_ALIGN_CHECK_EN: load of 0x32 with be=1111 -> resp_err=1 for one cycle and rdata unchanged. Aligned load of 0x30 -> resp_err=0.
